// File: rtl/tile_line_sequencer.sv
// Purpose: per-scanline fetch controller; issues 2*TILES_PER_LINE half-tile reads, formats the returned words and tracks lb_x.
// Latency: address for read k in cycle 1+k after line_start, beat in cycle 2+k+BRAM_LAT, done in cycle N+BRAM_LAT+2.
// Backpressure: none; one read per cycle, a new line_start aborts the current line and flushes in-flight beats.
// Ports: clk_draw/rst_draw_n clock and async active-low reset; enable/line_start/line_y/scroll_x line request;
//        tile_y/tile_row/tile_x/tile_col BRAM address, tile_data BRAM read data;
//        tile_pixels/tile_valid_mask/lb_x/lb_clear to the quadrupler; busy/done line status.
module tile_line_sequencer #(
    parameter int TILES_PER_LINE = 32,
    parameter int BRAM_LAT       = 1,
    parameter int PIX_STEP       = 16,
    parameter int CORDW          = 11
) (
    input  logic             clk_draw,
    input  logic             rst_draw_n,
    input  logic             enable,
    input  logic             line_start,
    input  logic [9:0]       line_y,
    input  logic [CORDW-1:0] scroll_x,
    output logic [4:0]       tile_y,
    output logic [2:0]       tile_row,
    output logic [4:0]       tile_x,
    output logic             tile_col,
    input  logic [15:0]      tile_data,
    output logic [31:0]      tile_pixels,
    output logic [3:0]       tile_valid_mask,
    output logic [CORDW-1:0] lb_x,
    output logic             lb_clear,
    output logic             busy,
    output logic             done
);

    localparam logic [5:0] LAST_IDX = 6'(2 * TILES_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t               state, state_nxt;
    logic [5:0]           read_idx, read_idx_nxt;
    logic                 issue, issue_nxt;        // current address output is a live read
    logic [BRAM_LAT-1:0]  vld_pipe, vld_pipe_nxt;  // bit BRAM_LAT-1 set => tile_data valid now
    logic [4:0]           tile_y_nxt;
    logic [2:0]           tile_row_nxt;
    logic [31:0]          tile_pixels_nxt;
    logic [3:0]           tile_valid_mask_nxt;
    logic [CORDW-1:0]     lb_x_nxt;
    logic                 lb_clear_nxt, busy_nxt, done_nxt;
    logic                 start, abort, beat;

    // Pixel rows within a tile are 4 scanlines tall; the low line bits do not address the BRAM.
    logic line_y_unused;
    assign line_y_unused = ^line_y[1:0];

    assign tile_x   = read_idx[5:1];
    assign tile_col = read_idx[0];
    assign beat     = vld_pipe[BRAM_LAT-1];

    always_comb begin
        state_nxt           = state;
        read_idx_nxt        = read_idx;
        issue_nxt           = 1'b0;
        vld_pipe_nxt[0]     = issue;
        for (int i = 1; i < BRAM_LAT; i++) begin
            vld_pipe_nxt[i] = vld_pipe[i-1];
        end
        tile_y_nxt          = tile_y;
        tile_row_nxt        = tile_row;
        tile_pixels_nxt     = beat ? {4'h0, tile_data[15:12], 4'h0, tile_data[11:8],
                                      4'h0, tile_data[7:4],   4'h0, tile_data[3:0]} : 32'h0;
        tile_valid_mask_nxt = {4{beat}};
        // lb_x moves on after the beat it labelled has been presented
        lb_x_nxt            = (tile_valid_mask != 4'h0) ? lb_x + CORDW'(PIX_STEP) : lb_x;
        lb_clear_nxt        = 1'b0;
        start               = 1'b0;
        abort               = 1'b0;

        case (state)
            IDLE: begin
                start = line_start && enable;
            end
            FETCH: begin
                if (read_idx == LAST_IDX) begin
                    state_nxt = DRAIN;  // address outputs hold the last read
                end else begin
                    read_idx_nxt = read_idx + 6'd1;
                    issue_nxt    = 1'b1;
                end
                start = line_start && enable;
                abort = line_start && !enable;
            end
            DRAIN: begin
                if (vld_pipe == '0) begin
                    state_nxt = DONE;
                end
                start = line_start && enable;
                abort = line_start && !enable;
            end
            DONE: begin
                state_nxt = IDLE;
                start     = line_start && enable;
            end
            default: state_nxt = IDLE;
        endcase

        // Any line_start in flight kills every outstanding read of the old line,
        // including the beat that would have been registered this cycle.
        if (start || abort) begin
            vld_pipe_nxt        = '0;
            tile_pixels_nxt     = 32'h0;
            tile_valid_mask_nxt = 4'h0;
        end

        if (start) begin
            state_nxt    = FETCH;
            read_idx_nxt = 6'd0;
            issue_nxt    = 1'b1;
            tile_y_nxt   = line_y[9:5];
            tile_row_nxt = line_y[4:2];
            lb_x_nxt     = scroll_x;
            lb_clear_nxt = 1'b1;
        end else if (abort) begin
            state_nxt = IDLE;
            issue_nxt = 1'b0;
        end

        busy_nxt = (state_nxt == FETCH) || (state_nxt == DRAIN);
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
        if (!rst_draw_n) begin
            state           <= IDLE;
            read_idx        <= 6'd0;
            issue           <= 1'b0;
            vld_pipe        <= '0;
            tile_y          <= 5'd0;
            tile_row        <= 3'd0;
            tile_pixels     <= 32'h0;
            tile_valid_mask <= 4'h0;
            lb_x            <= '0;
            lb_clear        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state           <= state_nxt;
            read_idx        <= read_idx_nxt;
            issue           <= issue_nxt;
            vld_pipe        <= vld_pipe_nxt;
            tile_y          <= tile_y_nxt;
            tile_row        <= tile_row_nxt;
            tile_pixels     <= tile_pixels_nxt;
            tile_valid_mask <= tile_valid_mask_nxt;
            lb_x            <= lb_x_nxt;
            lb_clear        <= lb_clear_nxt;
            busy            <= busy_nxt;
            done            <= done_nxt;
        end
    end

endmodule

// File: tb/tb_tile_line_sequencer.sv
// Purpose: scoreboard bench for tile_line_sequencer with BRAM_LAT=1 (dut a) and BRAM_LAT=3 (dut b) side by side.
// Latency: expected beats carry their absolute cycle; done pulses are queued with their absolute cycle.
// Backpressure: none; a new line_start drops every queued expectation later than its own cycle 0.
module tb_tile_line_sequencer;

    logic        clk_draw = 1'b0;
    logic        rst_draw_n = 1'b0;
    logic        enable = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  line_y = 10'd0;
    logic [10:0] scroll_x = 11'd0;

    logic [4:0]  a_tile_y, b_tile_y, a_tile_x, b_tile_x;
    logic [2:0]  a_tile_row, b_tile_row;
    logic        a_tile_col, b_tile_col;
    logic [15:0] a_tile_data, b_tile_data;
    logic [31:0] a_pix, b_pix;
    logic [3:0]  a_mask, b_mask;
    logic [10:0] a_lb_x, b_lb_x;
    logic        a_lb_clear, b_lb_clear, a_busy, b_busy, a_done, b_done;

    tile_line_sequencer #(.TILES_PER_LINE(32), .BRAM_LAT(1), .PIX_STEP(16), .CORDW(11)) u_dut_a (
        .clk_draw(clk_draw), .rst_draw_n(rst_draw_n), .enable(enable), .line_start(line_start),
        .line_y(line_y), .scroll_x(scroll_x), .tile_y(a_tile_y), .tile_row(a_tile_row),
        .tile_x(a_tile_x), .tile_col(a_tile_col), .tile_data(a_tile_data), .tile_pixels(a_pix),
        .tile_valid_mask(a_mask), .lb_x(a_lb_x), .lb_clear(a_lb_clear), .busy(a_busy), .done(a_done)
    );

    tile_line_sequencer #(.TILES_PER_LINE(32), .BRAM_LAT(3), .PIX_STEP(16), .CORDW(11)) u_dut_b (
        .clk_draw(clk_draw), .rst_draw_n(rst_draw_n), .enable(enable), .line_start(line_start),
        .line_y(line_y), .scroll_x(scroll_x), .tile_y(b_tile_y), .tile_row(b_tile_row),
        .tile_x(b_tile_x), .tile_col(b_tile_col), .tile_data(b_tile_data), .tile_pixels(b_pix),
        .tile_valid_mask(b_mask), .lb_x(b_lb_x), .lb_clear(b_lb_clear), .busy(b_busy), .done(b_done)
    );

    always #5 clk_draw = ~clk_draw;

    int cyc = 0;
    always @(posedge clk_draw) cyc <= cyc + 1;

    // Tile memory contents, same for every line; word 0 is the formatting vector.
    logic [15:0] mem [64];
    logic [15:0] a_d1, b_d1, b_d2, b_d3;
    always @(posedge clk_draw) begin
        a_d1 <= mem[{a_tile_x, a_tile_col}];
        b_d1 <= mem[{b_tile_x, b_tile_col}];
        b_d2 <= b_d1;
        b_d3 <= b_d2;
    end
    assign a_tile_data = a_d1;
    assign b_tile_data = b_d3;

    logic [63:0] a_outs, b_outs;
    assign a_outs = {a_tile_y, a_tile_row, a_tile_x, a_tile_col, a_pix, a_mask, a_lb_x, a_lb_clear, a_busy, a_done};
    assign b_outs = {b_tile_y, b_tile_row, b_tile_x, b_tile_col, b_pix, b_mask, b_lb_x, b_lb_clear, b_busy, b_done};

    typedef struct {
        int          cyc;
        logic [31:0] pix;
        logic [10:0] x;
    } beat_t;

    beat_t q_a[$];
    beat_t q_b[$];
    int    dq_a[$];
    int    dq_b[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fmt(input logic [15:0] d);
        return {4'h0, d[15:12], 4'h0, d[11:8], 4'h0, d[7:4], 4'h0, d[3:0]};
    endfunction

    // Monitors: every presented beat and done pulse is matched against the scoreboard.
    always @(negedge clk_draw) begin
        beat_t e;
        if (a_mask != 4'h0) begin
            chk("a_mask", a_mask, 4'hf);
            if (q_a.size() == 0) begin
                chk("a_unexpected_beat", 1, 0);
            end else begin
                e = q_a.pop_front();
                chk("a_beat_cycle", cyc, e.cyc);
                chk("a_pixels", a_pix, e.pix);
                chk("a_lb_x", a_lb_x, e.x);
            end
        end
        if (a_done) begin
            if (dq_a.size() == 0) chk("a_unexpected_done", 1, 0);
            else chk("a_done_cycle", cyc, dq_a.pop_front());
        end
    end

    always @(negedge clk_draw) begin
        beat_t e;
        if (b_mask != 4'h0) begin
            chk("b_mask", b_mask, 4'hf);
            if (q_b.size() == 0) begin
                chk("b_unexpected_beat", 1, 0);
            end else begin
                e = q_b.pop_front();
                chk("b_beat_cycle", cyc, e.cyc);
                chk("b_pixels", b_pix, e.pix);
                chk("b_lb_x", b_lb_x, e.x);
            end
        end
        if (b_done) begin
            if (dq_b.size() == 0) chk("b_unexpected_done", 1, 0);
            else chk("b_done_cycle", cyc, dq_b.pop_front());
        end
    end

    // Drives a one-cycle line_start (its cycle is returned as t0), cancels expectations the
    // pulse kills, and queues the new line. rm_a/rm_b count cancelled beats.
    task automatic issue_line(input logic en, input logic [9:0] y, input logic [10:0] sx,
                              output int t0, output int rm_a, output int rm_b);
        beat_t e;
        @(posedge clk_draw); #1;
        line_start = 1'b1;
        enable     = en;
        line_y     = y;
        scroll_x   = sx;
        t0         = cyc;
        rm_a = 0;
        rm_b = 0;
        for (int i = q_a.size() - 1; i >= 0; i--) if (q_a[i].cyc > t0) begin q_a.delete(i); rm_a++; end
        for (int i = q_b.size() - 1; i >= 0; i--) if (q_b[i].cyc > t0) begin q_b.delete(i); rm_b++; end
        for (int i = dq_a.size() - 1; i >= 0; i--) if (dq_a[i] > t0) dq_a.delete(i);
        for (int i = dq_b.size() - 1; i >= 0; i--) if (dq_b[i] > t0) dq_b.delete(i);
        if (en) begin
            for (int k = 0; k < 64; k++) begin
                e.pix = (k == 0) ? 32'h0A050C03 : fmt(mem[k]);
                e.x   = 11'(sx + 11'(16 * k));
                e.cyc = t0 + k + 3;
                q_a.push_back(e);
                e.cyc = t0 + k + 5;
                q_b.push_back(e);
            end
            dq_a.push_back(t0 + 67);
            dq_b.push_back(t0 + 69);
        end
        @(posedge clk_draw); #1;
        line_start = 1'b0;
        enable     = 1'b0;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk_draw); #1;
        end
    endtask

    task automatic chk_drained(input string name);
        chk({name, "_beats_left_a"}, q_a.size(), 0);
        chk({name, "_beats_left_b"}, q_b.size(), 0);
        chk({name, "_done_left_a"}, dq_a.size(), 0);
        chk({name, "_done_left_b"}, dq_b.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t0, t1, rm_a, rm_b;
        mem[0] = 16'hA5C3;
        for (int k = 1; k < 64; k++) mem[k] = 16'(k * 4951) ^ 16'h2468;

        // Reset state
        repeat (3) @(posedge clk_draw);
        #1;
        chk("reset_outs_a", a_outs, 64'h0);
        chk("reset_outs_b", b_outs, 64'h0);
        rst_draw_n = 1'b1;
        wait_to(cyc + 3);

        // Basic line: y=37 -> tile_y=1, tile_row=1
        issue_line(1'b1, 10'd37, 11'd5, t0, rm_a, rm_b);
        chk("basic_lb_clear_a", a_lb_clear, 1);
        chk("basic_lb_clear_b", b_lb_clear, 1);
        chk("basic_busy_a", a_busy, 1);
        chk("basic_tile_y", a_tile_y, 5'd1);
        chk("basic_tile_row", a_tile_row, 3'd1);
        chk("basic_addr_c1", {a_tile_x, a_tile_col}, 6'd0);
        chk("basic_mask_c1", a_mask, 4'h0);
        wait_to(t0 + 2);
        chk("basic_lb_clear_c2", a_lb_clear, 0);
        chk("basic_addr_c2", {a_tile_x, a_tile_col}, 6'd1);
        chk("basic_mask_c2", a_mask, 4'h0);
        wait_to(t0 + 64);
        chk("basic_addr_c64_a", {a_tile_x, a_tile_col}, 6'd63);
        chk("basic_addr_c64_b", {b_tile_x, b_tile_col}, 6'd63);
        wait_to(t0 + 66);
        chk("basic_addr_hold", {a_tile_x, a_tile_col}, 6'd63);
        chk("basic_busy_c66", a_busy, 1);
        wait_to(t0 + 67);
        chk("basic_busy_done_cycle", a_busy, 0);
        wait_to(t0 + 72);
        chk_drained("basic");

        // Latency / wrap: first lb_x 2040, second wraps to 8
        issue_line(1'b1, 10'd100, 11'd2040, t0, rm_a, rm_b);
        wait_to(t0 + 72);
        chk_drained("wrap");

        // Abort at cycle 20: 18 (lat1) / 16 (lat3) old beats survive
        issue_line(1'b1, 10'd37, 11'd5, t0, rm_a, rm_b);
        wait_to(t0 + 19);
        issue_line(1'b1, 10'd200, 11'd100, t1, rm_a, rm_b);
        chk("abort_cycle0", t1 - t0, 20);
        chk("abort_cancelled_a", rm_a, 46);
        chk("abort_cancelled_b", rm_b, 48);
        chk("abort_lb_clear", a_lb_clear, 1);
        chk("abort_tile_y", a_tile_y, 5'd6);
        chk("abort_tile_row", a_tile_row, 3'd2);
        chk("abort_addr", {a_tile_x, a_tile_col}, 6'd0);
        wait_to(t1 + 72);
        chk_drained("abort");

        // line_start in the lat1 DONE cycle (lat3 is still draining)
        issue_line(1'b1, 10'd37, 11'd5, t0, rm_a, rm_b);
        wait_to(t0 + 66);
        issue_line(1'b1, 10'd64, 11'd0, t1, rm_a, rm_b);
        chk("donecoin_cancelled_a", rm_a, 0);
        chk("donecoin_cancelled_b", rm_b, 1);
        chk("donecoin_lb_clear", a_lb_clear, 1);
        chk("donecoin_tile_y", a_tile_y, 5'd2);
        wait_to(t1 + 72);
        chk_drained("donecoin");

        // Enable low while busy: abort to IDLE, no lb_clear
        issue_line(1'b1, 10'd37, 11'd5, t0, rm_a, rm_b);
        wait_to(t0 + 9);
        issue_line(1'b0, 10'd37, 11'd5, t1, rm_a, rm_b);
        chk("enbusy_cancelled_a", rm_a, 56);
        chk("enbusy_cancelled_b", rm_b, 58);
        chk("enbusy_busy", {a_busy, b_busy}, 2'b00);
        chk("enbusy_lb_clear", {a_lb_clear, b_lb_clear}, 2'b00);
        wait_to(t1 + 10);
        chk_drained("enbusy");

        // Enable low while idle: nothing for 100 cycles
        issue_line(1'b0, 10'd37, 11'd5, t0, rm_a, rm_b);
        for (int i = 0; i < 100; i++) begin
            chk("enidle_quiet", {a_busy, a_lb_clear, a_mask, b_busy, b_lb_clear, b_mask}, 12'h0);
            @(posedge clk_draw); #1;
        end
        chk_drained("enidle");

        // Reset mid-line at cycle 30
        issue_line(1'b1, 10'd37, 11'd5, t0, rm_a, rm_b);
        wait_to(t0 + 30);
        rst_draw_n = 1'b0;
        q_a.delete();
        q_b.delete();
        dq_a.delete();
        dq_b.delete();
        #1;
        chk("midreset_outs_a", a_outs, 64'h0);
        chk("midreset_outs_b", b_outs, 64'h0);
        wait_to(cyc + 3);
        rst_draw_n = 1'b1;
        wait_to(cyc + 2);
        chk("postreset_outs_a", a_outs, 64'h0);
        issue_line(1'b1, 10'd37, 11'd5, t0, rm_a, rm_b);
        chk("postreset_lb_clear", a_lb_clear, 1);
        chk("postreset_tile_y", a_tile_y, 5'd1);
        wait_to(t0 + 72);
        chk_drained("postreset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
